// File: rtl/aes_pkg.sv
// Shared constants and AES helper functions for the self-test top:
// FIPS-197 test vectors, seven-segment digit codes, and round/key-schedule math.
package aes_pkg;

  localparam logic [127:0] AES_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] AES_KEY_FULL =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  // Active-low segment codes, bit0=a ... bit6=g, indexed by decimal digit.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {
    PH_RESET,
    PH_CT,
    PH_DT,
    PH_PT
  } phase_e;

  function automatic logic [127:0] expected_ct(input int nk);
    case (nk)
      6:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      8:       return 128'h8ea2b7ca516745bfeafc49904b496089;
      default: return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    endcase
  endfunction

  function automatic int nk_to_nr(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // State byte n sits at bits [127-8n -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int j = 0; j < 16; j++)
      o[127 - 8*j -: 8] = inv ? inv_sbox(s[127 - 8*j -: 8]) : sbox(s[127 - 8*j -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src + r) -: 8];
      end
    end
    return o;
  endfunction

  // Circulant matrix rows: coefficient for a_j in row i is m[(j-i) mod 4].
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  mv;
    logic [7:0]   acc;
    mv = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gf_mul(mv[31 - 8*((j - i + 4) % 4) -: 8], s[127 - 8*(4*c + j) -: 8]);
        o[127 - 8*(4*c + i) -: 8] = acc;
      end
    end
    return o;
  endfunction

  // Key is left-aligned in 256 bits; only the first nk words are used.
  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) begin
        w[i] = key[255 - 32*i -: 32];
      end else begin
        t = w[i - 1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i - nk] ^ t;
      end
    end
    return {w[4*r], w[4*r + 1], w[4*r + 2], w[4*r + 3]};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
    if (!last) t = mix_columns(t, 1'b0);
    return t ^ rk;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk;
    if (!last) t = mix_columns(t, 1'b1);
    return t;
  endfunction

endpackage

// File: rtl/aes_selftest_display_7seg.sv
// Registered byte-to-decimal seven-segment driver (hundreds/tens/units,
// leading zeros shown). Reset shows "000".
module ls_byte_7seg
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  output logic [6:0] seg_units,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_hundreds
);

  logic [6:0] units_q, units_d;
  logic [6:0] tens_q, tens_d;
  logic [6:0] hund_q, hund_d;

  function automatic logic [3:0] dec_digit(input logic [7:0] v, input logic [7:0] div);
    return 4'((v / div) % 8'd10);
  endfunction

  always_comb begin
    units_d = SEG_TABLE[dec_digit(byte_in, 8'd1)];
    tens_d  = SEG_TABLE[dec_digit(byte_in, 8'd10)];
    hund_d  = SEG_TABLE[dec_digit(byte_in, 8'd100)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      units_q <= 7'h40;
      tens_q  <= 7'h40;
      hund_q  <= 7'h40;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
    end
  end

  assign seg_units    = units_q;
  assign seg_tens     = tens_q;
  assign seg_hundreds = hund_q;

endmodule

// File: rtl/cipherEN.sv
// Iterative AES encrypt core: initial key add plus Nr rounds, one per clock,
// so the ciphertext is on out_block Nr+1 clocks after reset release.
module cipherEN
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [127:0]      in_block,
  input  logic [32*Nk-1:0]  key,
  output logic [127:0]      out_block
);

  localparam logic [3:0] LAST = 4'(Nr);

  logic [3:0]   round_q, round_d, rk_idx;
  logic [127:0] state_q, state_d, rk;
  logic [255:0] key_al;

  assign key_al = 256'(key) << (256 - 32*Nk);

  always_comb begin
    round_d = round_q;
    state_d = state_q;
    rk_idx  = (round_q > LAST) ? LAST : round_q;
    rk      = round_key(key_al, Nk, int'(rk_idx));
    if (round_q == 4'd0) begin
      state_d = in_block ^ rk;
      round_d = 4'd1;
    end else if (round_q <= LAST) begin
      state_d = enc_round(state_q, rk, round_q == LAST);
      round_d = round_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_q <= '0;
      state_q <= '0;
    end else begin
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  assign out_block = state_q;

endmodule

// File: rtl/decipherDE.sv
// Iterative AES decrypt core (standard inverse cipher). It idles until the
// encrypt core's result is stable, then takes Nr+1 clocks to produce plaintext.
module decipherDE
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [127:0]      in_block,
  input  logic [32*Nk-1:0]  key,
  output logic [127:0]      out_block
);

  localparam logic [4:0] START = 5'(Nr + 1);
  localparam logic [4:0] DONE  = 5'(2*Nr + 2);

  logic [4:0]   phase_q, phase_d, step;
  logic [127:0] state_q, state_d, rk;
  logic [255:0] key_al;
  int           rk_idx;

  assign key_al = 256'(key) << (256 - 32*Nk);

  always_comb begin
    phase_d = (phase_q == DONE) ? phase_q : phase_q + 5'd1;
    state_d = state_q;
    step    = phase_q - START;
    rk_idx  = (phase_q >= START && phase_q < DONE) ? Nr - int'(step) : 0;
    rk      = round_key(key_al, Nk, rk_idx);
    if (phase_q == START)
      state_d = in_block ^ rk;
    else if (phase_q > START && phase_q < DONE)
      state_d = dec_round(state_q, rk, phase_q == DONE - 5'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      state_q <= '0;
    end else begin
      phase_q <= phase_d;
      state_q <= state_d;
    end
  end

  assign out_block = state_q;

endmodule

// File: rtl/aes_selftest_display.sv
// Board top: encrypt the FIPS-197 vector, decrypt it back, then show the
// plaintext; LS byte of the current stage goes to three 7-seg digits.
module aes_selftest_display
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] Seg1,
  output logic [6:0] Seg2,
  output logic [6:0] Seg3,
  output logic       LED
);

  localparam logic [4:0]         CT_LAST = 5'(Nr + 1);
  localparam logic [4:0]         DT_LAST = 5'(2*(Nr + 1));
  localparam logic [4:0]         CNT_MAX = 5'(2*(Nr + 1) + 1);
  localparam logic [32*Nk-1:0]   KEY     = AES_KEY_FULL[255 -: 32*Nk];

  logic [4:0]   count_q, count_d;
  logic [127:0] ct, dt;
  logic [7:0]   db;
  phase_e       phase;

  cipherEN #(.Nk(Nk), .Nr(Nr)) u_enc (
    .clk       (clk),
    .reset     (reset),
    .in_block  (AES_PT),
    .key       (KEY),
    .out_block (ct)
  );

  decipherDE #(.Nk(Nk), .Nr(Nr)) u_dec (
    .clk       (clk),
    .reset     (reset),
    .in_block  (ct),
    .key       (KEY),
    .out_block (dt)
  );

  always_comb begin
    count_d = (count_q == CNT_MAX) ? count_q : count_q + 5'd1;
    if (reset)                 phase = PH_RESET;
    else if (count_q <= CT_LAST) phase = PH_CT;
    else if (count_q <= DT_LAST) phase = PH_DT;
    else                       phase = PH_PT;
  end

  // LED is a live compare, so it is low while the ciphertext is on display.
  always_comb begin
    db  = 8'h00;
    LED = 1'b0;
    case (phase)
      PH_CT: begin
        db  = ct[7:0];
        LED = (ct == AES_PT);
      end
      PH_DT: begin
        db  = dt[7:0];
        LED = (dt == AES_PT);
      end
      PH_PT: begin
        db  = AES_PT[7:0];
        LED = 1'b1;
      end
      default: begin
        db  = 8'h00;
        LED = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  ls_byte_7seg u_seg (
    .clk          (clk),
    .reset        (reset),
    .byte_in      (db),
    .seg_units    (Seg1),
    .seg_tens     (Seg2),
    .seg_hundreds (Seg3)
  );

endmodule

// File: tb/tb_aes_selftest_display.sv
// Bench for aes_selftest_display: runs AES-128/192/256 tops side by side
// under random reset pulses and checks them against a cycle-level model.
module tb_aes_selftest_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg1 [3];
  logic [6:0] seg2 [3];
  logic [6:0] seg3 [3];
  logic       led  [3];
  logic [4:0] cnt  [3];

  int checks = 0;
  int failures = 0;
  int k = 0;

  // {count, seg3, seg2, seg1, led}
  logic [26:0] exp_q [$];
  logic [26:0] msk_q [$];

  always #5 clk = ~clk;

  aes_selftest_display #(.Nk(4), .Nr(10)) u128 (
    .clk(clk), .reset(reset), .Seg1(seg1[0]), .Seg2(seg2[0]), .Seg3(seg3[0]), .LED(led[0]));
  aes_selftest_display #(.Nk(6), .Nr(12)) u192 (
    .clk(clk), .reset(reset), .Seg1(seg1[1]), .Seg2(seg2[1]), .Seg3(seg3[1]), .LED(led[1]));
  aes_selftest_display #(.Nk(8), .Nr(14)) u256 (
    .clk(clk), .reset(reset), .Seg1(seg1[2]), .Seg2(seg2[2]), .Seg3(seg3[2]), .LED(led[2]));

  assign cnt[0] = u128.count_q;
  assign cnt[1] = u192.count_q;
  assign cnt[2] = u256.count_q;

  function automatic int nr_of(input int d);
    return 10 + 2*d;
  endfunction

  function automatic int ct_lsb_of(input int d);
    case (d)
      0:       return 'h5a;
      1:       return 'h91;
      default: return 'h89;
    endcase
  endfunction

  function automatic logic [20:0] lit_of(input int d);
    case (d)
      0:       return {7'h40, 7'h10, 7'h40};
      1:       return {7'h79, 7'h19, 7'h12};
      default: return {7'h79, 7'h30, 7'h78};
    endcase
  endfunction

  function automatic logic [6:0] seg_pat(input int digit);
    case (digit)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  function automatic logic [20:0] disp_of(input int v);
    return {seg_pat(v / 100), seg_pat((v / 10) % 10), seg_pat(v % 10)};
  endfunction

  // Model: k = rising edges since reset release; count saturates at 2(Nr+1)+1,
  // the display shows the byte selected one cycle earlier.
  task automatic model(input int d, input logic rst, input int kk,
                       output logic [26:0] e, output logic [26:0] m);
    int nr, cmax, c;
    logic l;
    if (rst) begin
      e = {5'd0, 7'h40, 7'h40, 7'h40, 1'b0};
      m = '1;
    end else begin
      nr   = nr_of(d);
      cmax = 2*(nr + 1) + 1;
      c    = (kk < cmax) ? kk : cmax;
      l    = (kk >= 2*(nr + 1));
      e    = {5'(c), 21'd0, l};
      m    = {5'h1f, 21'd0, 1'b1};
      if (kk == nr + 2) begin
        e[21:1] = disp_of(ct_lsb_of(d));
        m[21:1] = '1;
      end else if (kk >= cmax) begin
        e[21:1] = disp_of(255);
        m[21:1] = '1;
      end
    end
  endtask

  always @(posedge clk) begin
    logic [26:0] e, m;
    #1;
    if (reset) k = 0;
    else k++;
    for (int d = 0; d < 3; d++) begin
      model(d, reset, k, e, m);
      exp_q.push_back(e);
      msk_q.push_back(m);
    end
  end

  always @(negedge clk) begin
    logic [26:0] got, e, m;
    for (int d = 0; d < 3; d++) begin
      got = {cnt[d], seg3[d], seg2[d], seg1[d], led[d]};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL queue_empty dut=%0d got=%h", d, got);
      end else begin
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        if (((got ^ e) & m) != 27'd0) begin
          failures++;
          $display("FAIL cycle_model dut=%0d k=%0d got=%h exp=%h mask=%h", d, k, got, e, m);
        end
      end
      if (!reset && k == nr_of(d) + 2) begin
        checks++;
        if (got[21:1] != lit_of(d)) begin
          failures++;
          $display("FAIL ct_display dut=%0d got=%h exp=%h", d, got[21:1], lit_of(d));
        end
      end
      if (!reset && k >= 2*(nr_of(d) + 1) + 1) begin
        checks++;
        if (got[21:0] != {7'h24, 7'h12, 7'h12, 1'b1}) begin
          failures++;
          $display("FAIL final_255 dut=%0d got=%h exp=%h", d, got[21:0],
                   {7'h24, 7'h12, 7'h12, 1'b1});
        end
      end
    end
  end

  task automatic check_async();
    logic [26:0] got;
    for (int d = 0; d < 3; d++) begin
      got = {cnt[d], seg3[d], seg2[d], seg1[d], led[d]};
      checks++;
      if (got != {5'd0, 7'h40, 7'h40, 7'h40, 1'b0}) begin
        failures++;
        $display("FAIL async_reset dut=%0d got=%h exp=%h", d, got,
                 {5'd0, 7'h40, 7'h40, 7'h40, 1'b0});
      end
    end
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_async();
    repeat (hold) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    run(40);
    pulse_reset(2);
    run(15);
    pulse_reset(3);
    run(40);
    for (int i = 0; i < 10; i++) begin
      pulse_reset($urandom_range(1, 3));
      run($urandom_range(1, 36));
    end
    pulse_reset(1);
    run(40);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_selftest_display.md
Name: aes_selftest_display

Overview:
- Self-test top for the AES datapath.
- Encrypts a fixed FIPS-197 plaintext with a fixed key, decrypts the result, then shows the plaintext again.
- Shows the least-significant byte of the current stage as a 3-digit decimal on three seven-segment displays.
- Drives one pass/fail LED; intended as the FPGA board top for one key size.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8 selects AES-128/192/256).
- Nr, 10, round count (10/12/14; must match Nk).

Ports:
- clk  input  1  single system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Seg1  output  7  units digit of displayed byte.
- Seg2  output  7  tens digit of displayed byte.
- Seg3  output  7  hundreds digit of displayed byte.
- LED  output  1  pass indicator.

Behaviour:
- Constants:
  - plaintext PT = 128'h00112233445566778899aabbccddeeff.
  - Key = 000102...0f, truncated to Nk*32 bits (16/24/32 bytes, ascending).
  - Expected ciphertext:
    - AES-128: 69c4e0d86a7b0430d8cdb78070b4c55a.
    - AES-192: dda97ca4864cdfe06eaf70a0ec0d7191.
    - AES-256: 8ea2b7ca516745bfeafc49904b496089.
- Datapath: existing iterative cipherEN #(Nk,Nr) encrypts PT → CT. Existing decipherDE #(Nk,Nr) takes CT and the same key → DT. Both take clk and reset. Each completes in Nr+1 clocks.
- Phase counter Count, 5 bits:
  - Async reset to 0.
  - Increments by 1 per clock until it reaches 2*(Nr+1)+1, then holds (saturates).
  - Reset mid-run returns Count to 0 and restarts the sequence.
- Display byte DB (combinational) and LED:
  - reset high: DB=8'h00, LED=0.
  - Count ≤ Nr+1: DB=CT[7:0]; LED=(CT==PT). This is 0 for a correct design.
  - Nr+2 ≤ Count ≤ 2*(Nr+1): DB=DT[7:0]; LED=(DT==PT).
  - Count ≥ 2*(Nr+1)+1: DB=PT[7:0]=8'hff; LED=1.
- Seven-segment encoding (sub-module ls_byte_7seg):
  - Splits DB into hundreds/tens/units, range 0..255.
  - Encodes each digit active-low. Bit0=a … bit6=g.
  - Codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Leading zeros are shown, not blanked.
  - Outputs registered on clk: one-cycle latency from DB.
  - Reset drives all three outputs to 7'h40 ("000").
- Steady-state final display, all key sizes: Seg3/Seg2/Seg1 = "2","5","5" = 24/12/12; LED=1.
- Final ciphertext LS-byte display:
  - AES-128: 5a → "090" (40/10/40).
  - AES-192: 91 → "145" (79/19/12).
  - AES-256: 89 → "137" (79/30/78).
- Parameter combinations other than (4,10), (6,12), (8,14) are unsupported.

Decomposition:
- Shared package aes_pkg:
  - PT and key constants.
  - Expected-CT constants per key size.
  - The 10-entry seven-segment digit table.
  - A function mapping Nk → Nr.
- Sub-module ls_byte_7seg:
  - Ports: clk, reset, 8-bit byte in, three 7-bit outputs.
  - Does the binary-to-decimal split (divide/modulo by constants or double-dabble) and table lookup.
- Top contains: Count, phase mux, LED compare, instances of cipherEN, decipherDE, ls_byte_7seg.

Test Plan:
- Reset asserted asynchronously between clock edges → Count=0, LED=0, Seg1..3=7'h40 immediately. Outputs hold while reset is high.
- Nk=4,Nr=10, release reset, run 11 clocks → Count=11, CT=69c4…c55a, Seg3/2/1=40/10/40 one clock later, LED=0.
- Continue to Count=22 → DT=00112233…eeff, display "255" (24/12/12), LED=1.
- Continue 10 more clocks → Count saturates at 23 and never changes; display "255", LED=1.
- Repeat with Nk=6,Nr=12 and Nk=8,Nr=14:
  - CT ends at the Nr+1 boundary with dda9…7191 and 8ea2…6089.
  - Displays "145" and "137"; saturation at 27 and 31 respectively.
- Reset pulse asserted at Count=15 (Nk=4) → Count=0, display "000". The full sequence replays identically after release.
